// File: rtl/othello_pkg.sv
// Shared types and constants for the alpha-beta search pipeline and its
// result-collection back end.
package othello_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SCORE_MIN = -64;
  localparam int SCORE_MAX = 64;
  localparam int TASKID_W  = 16;
  localparam int SPUR_W    = 16;

  typedef struct packed {
    logic [15:0]       taskid;
    logic signed [7:0] score;
    logic [2:0]        slot;
  } result_t;

  localparam int RESULT_W = $bits(result_t);

  // Saturating increment for event counters that must never wrap back to 0.
  function automatic logic [SPUR_W-1:0] satInc16(input logic [SPUR_W-1:0] value);
    return (value == {SPUR_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO on a register array; the head entry is
// visible on data_o whenever empty_o is low.
module sync_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             doPush;
  logic             doPop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty_o = !valid_q;
  assign data_o  = mem_q[rdPtr_q[AW-1:0]];

  // A pop frees a slot this cycle, so a push into a full FIFO still lands.
  assign doPop  = pop_i && valid_q;
  assign doPush = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    valid_d = (wrPtr_d != rdPtr_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      valid_q <= valid_d;
      if (doPush) begin
        mem_q[wrPtr_q[AW-1:0]] <= data_i;
      end
    end
  end

endmodule

// File: rtl/result_collector.sv
// Matches pipeline solve pulses against a bitmap of issued task ids and queues
// accepted results for the host reader; unmatched solves are only counted.
module result_collector
  import othello_pkg::*;
#(
  parameter int IDW   = 6,
  parameter int DEPTH = 16
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iIssue,
  input  logic [15:0]       iIssueTaskid,
  input  logic              iSolved,
  input  logic [15:0]       iTaskid,
  input  logic signed [7:0] iRes,
  input  logic [2:0]        iSlot,
  output logic              oValid,
  input  logic              iReady,
  output logic [15:0]       oTaskid,
  output logic signed [7:0] oScore,
  output logic [2:0]        oSlot,
  output logic [IDW:0]      oOutstanding,
  output logic [15:0]       oSpurious,
  output logic              oOverflow,
  output logic              oDupIssue
);

  localparam int NIDS = 1 << IDW;

  logic [NIDS-1:0] pend_q, pend_d;
  logic [IDW:0]    outstanding_q, outstanding_d;
  logic [15:0]     spurious_q, spurious_d;
  logic            overflow_q, overflow_d;
  logic            dupIssue_q, dupIssue_d;

  logic [IDW-1:0]  issueIdx;
  logic [IDW-1:0]  solveIdx;
  logic            solveMatch;
  logic            sameIdxMatch;
  logic            issueAdds;
  logic            popHead;
  logic            fifoFull;
  logic            fifoEmpty;
  result_t         pushData;
  result_t         headData;
  logic            unusedIdHigh;

  assign issueIdx     = iIssueTaskid[IDW-1:0];
  assign solveIdx     = iTaskid[IDW-1:0];
  assign unusedIdHigh = ^{iIssueTaskid[15:IDW]};

  // Match uses the pre-cycle bitmap; a same-index issue re-arms the cleared bit,
  // so it counts as a fresh issue rather than a duplicate.
  assign solveMatch   = iSolved && pend_q[solveIdx];
  assign sameIdxMatch = iIssue && solveMatch && (issueIdx == solveIdx);
  assign issueAdds    = iIssue && (!pend_q[issueIdx] || sameIdxMatch);
  assign popHead      = oValid && iReady;

  always_comb begin
    pend_d = pend_q;
    if (solveMatch) begin
      pend_d[solveIdx] = 1'b0;
    end
    if (iIssue) begin
      pend_d[issueIdx] = 1'b1;
    end

    outstanding_d = outstanding_q;
    case ({issueAdds, solveMatch})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    spurious_d = (iSolved && !solveMatch) ? satInc16(spurious_q) : spurious_q;
    overflow_d = overflow_q || (solveMatch && fifoFull && !popHead);
    dupIssue_d = dupIssue_q || (iIssue && !issueAdds);
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      pend_q        <= '0;
      outstanding_q <= '0;
      spurious_q    <= '0;
      overflow_q    <= 1'b0;
      dupIssue_q    <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      outstanding_q <= outstanding_d;
      spurious_q    <= spurious_d;
      overflow_q    <= overflow_d;
      dupIssue_q    <= dupIssue_d;
    end
  end

  always_comb begin
    pushData        = '0;
    pushData.taskid = iTaskid;
    pushData.score  = iRes;
    pushData.slot   = iSlot;
  end

  sync_fifo #(
    .WIDTH(RESULT_W),
    .DEPTH(DEPTH)
  ) uFifo (
    .clk_i  (iCLOCK),
    .rst_i  (iRESET),
    .push_i (solveMatch),
    .pop_i  (popHead),
    .data_i (pushData),
    .data_o (headData),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

  assign oValid       = !fifoEmpty;
  assign oTaskid      = headData.taskid;
  assign oScore       = headData.score;
  assign oSlot        = headData.slot;
  assign oOutstanding = outstanding_q;
  assign oSpurious    = spurious_q;
  assign oOverflow    = overflow_q;
  assign oDupIssue    = dupIssue_q;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: a queue scoreboard of accepted
// results is filled from the driven solves and compared on every pop.
module tb_result_collector;
  import othello_pkg::*;

  logic              iCLOCK;
  logic              iRESET;
  logic              iIssue;
  logic [15:0]       iIssueTaskid;
  logic              iSolved;
  logic [15:0]       iTaskid;
  logic signed [7:0] iRes;
  logic [2:0]        iSlot;
  logic              oValid;
  logic              iReady;
  logic [15:0]       oTaskid;
  logic signed [7:0] oScore;
  logic [2:0]        oSlot;
  logic [6:0]        oOutstanding;
  logic [15:0]       oSpurious;
  logic              oOverflow;
  logic              oDupIssue;

  int vectors     = 0;
  int miscompares = 0;

  result_t    expQ[$];
  logic [63:0] mPend;
  result_t    expHead;
  result_t    newEntry;
  logic       popNow;
  logic       matchNow;

  result_collector #(.IDW(6), .DEPTH(16)) dut (
    .iCLOCK      (iCLOCK),
    .iRESET      (iRESET),
    .iIssue      (iIssue),
    .iIssueTaskid(iIssueTaskid),
    .iSolved     (iSolved),
    .iTaskid     (iTaskid),
    .iRes        (iRes),
    .iSlot       (iSlot),
    .oValid      (oValid),
    .iReady      (iReady),
    .oTaskid     (oTaskid),
    .oScore      (oScore),
    .oSlot       (oSlot),
    .oOutstanding(oOutstanding),
    .oSpurious   (oSpurious),
    .oOverflow   (oOverflow),
    .oDupIssue   (oDupIssue)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard sampled just before each rising edge, once inputs are settled.
  always @(negedge iCLOCK) begin
    #4;
    if (iRESET) begin
      expQ.delete();
      mPend = '0;
    end else begin
      popNow = (expQ.size() > 0) && iReady;
      if (popNow) begin
        checkOutput("headValid", {31'b0, oValid}, 32'd1);
        expHead = expQ.pop_front();
        checkOutput("popTaskid", {16'b0, oTaskid}, {16'b0, expHead.taskid});
        checkOutput("popScore", oScore, expHead.score);
        checkOutput("popSlot", {29'b0, oSlot}, {29'b0, expHead.slot});
      end else if (iReady) begin
        checkOutput("idleValid", {31'b0, oValid}, 32'd0);
      end
      matchNow = iSolved && mPend[iTaskid[5:0]];
      if (matchNow && expQ.size() < 16) begin
        newEntry.taskid = iTaskid;
        newEntry.score  = iRes;
        newEntry.slot   = iSlot;
        expQ.push_back(newEntry);
      end
      if (matchNow) mPend[iTaskid[5:0]] = 1'b0;
      if (iIssue) mPend[iIssueTaskid[5:0]] = 1'b1;
    end
  end

  task automatic applyStimulus(input logic issue, input logic [15:0] issueId,
                               input logic solved, input logic [15:0] solveId,
                               input logic signed [7:0] res, input logic [2:0] slot);
    iIssue       = issue;
    iIssueTaskid = issueId;
    iSolved      = solved;
    iTaskid      = solveId;
    iRes         = res;
    iSlot        = slot;
    @(negedge iCLOCK);
    iIssue  = 1'b0;
    iSolved = 1'b0;
  endtask

  task automatic issueId(input logic [15:0] id);
    applyStimulus(1'b1, id, 1'b0, 16'd0, 8'sd0, 3'd0);
  endtask

  task automatic solveId(input logic [15:0] id, input logic signed [7:0] res,
                         input logic [2:0] slot);
    applyStimulus(1'b0, 16'd0, 1'b1, id, res, slot);
  endtask

  task automatic drain(input int n);
    iReady = 1'b1;
    for (int k = 0; k < n; k++) begin
      checkOutput("drainValid", {31'b0, oValid}, 32'd1);
      @(negedge iCLOCK);
    end
    checkOutput("drainedEmpty", {31'b0, oValid}, 32'd0);
    iReady = 1'b0;
  endtask

  initial begin
    iRESET = 1'b1; iReady = 1'b0; iIssue = 1'b0; iIssueTaskid = '0;
    iSolved = 1'b0; iTaskid = '0; iRes = '0; iSlot = '0;
    repeat (3) @(negedge iCLOCK);
    iRESET = 1'b0;
    checkOutput("rstValid", {31'b0, oValid}, 32'd0);
    checkOutput("rstOutstanding", {25'b0, oOutstanding}, 32'd0);
    checkOutput("rstSpurious", {16'b0, oSpurious}, 32'd0);
    checkOutput("rstOverflow", {31'b0, oOverflow}, 32'd0);
    checkOutput("rstDupIssue", {31'b0, oDupIssue}, 32'd0);
    checkOutput("rstTaskid", {16'b0, oTaskid}, 32'd0);

    // Basic issue/solve round trip with one-cycle latency.
    issueId(16'd5);
    checkOutput("outstandingUp", {25'b0, oOutstanding}, 32'd1);
    solveId(16'd5, -8'sd12, 3'd3);
    checkOutput("firstValid", {31'b0, oValid}, 32'd1);
    checkOutput("firstTaskid", {16'b0, oTaskid}, 32'd5);
    checkOutput("firstScore", oScore, -32'sd12);
    checkOutput("firstSlot", {29'b0, oSlot}, 32'd3);
    checkOutput("outstandingDown", {25'b0, oOutstanding}, 32'd0);
    drain(1);

    // Unissued id is dropped and counted.
    solveId(16'd9, 8'sd0, 3'd0);
    checkOutput("spurValid", {31'b0, oValid}, 32'd0);
    checkOutput("spurCount", {16'b0, oSpurious}, 32'd1);

    // Fill to full, then push with a simultaneous pop: no overflow.
    for (int i = 20; i <= 36; i++) issueId(16'(i));
    checkOutput("outstanding17", {25'b0, oOutstanding}, 32'd17);
    for (int i = 20; i <= 35; i++) solveId(16'(i), 8'(i - 28), 3'(i));
    checkOutput("fullNoOvf", {31'b0, oOverflow}, 32'd0);
    iReady = 1'b1;
    solveId(16'd36, 8'sd8, 3'd4);
    checkOutput("pushPopFull", {31'b0, oOverflow}, 32'd0);
    checkOutput("outstandingA", {25'b0, oOutstanding}, 32'd0);
    drain(16);

    // Seventeen matched solves with the reader stalled: last one is lost.
    for (int i = 0; i <= 16; i++) issueId(16'(i));
    for (int i = 0; i <= 16; i++) solveId(16'(i), 8'(i * 4 - 32), 3'(i));
    checkOutput("overflowSet", {31'b0, oOverflow}, 32'd1);
    checkOutput("outstandingB", {25'b0, oOutstanding}, 32'd0);
    checkOutput("headIsZero", {16'b0, oTaskid}, 32'd0);
    drain(16);

    // Duplicate issue leaves the count at one.
    issueId(16'd2);
    issueId(16'd2);
    checkOutput("dupIssue", {31'b0, oDupIssue}, 32'd1);
    checkOutput("dupOutstanding", {25'b0, oOutstanding}, 32'd1);
    solveId(16'd2, 8'sd64, 3'd0);
    checkOutput("dupSolved", {25'b0, oOutstanding}, 32'd0);
    drain(1);

    // Same-cycle issue and matched solve of one index keeps the bit armed.
    issueId(16'd7);
    applyStimulus(1'b1, 16'd7, 1'b1, 16'd7, -8'sd64, 3'd5);
    checkOutput("sameOutstanding", {25'b0, oOutstanding}, 32'd1);
    checkOutput("sameTaskid", {16'b0, oTaskid}, 32'd7);
    checkOutput("sameScore", oScore, -32'sd64);
    solveId(16'd7, 8'sd5, 3'd6);
    checkOutput("reArmedMatch", {25'b0, oOutstanding}, 32'd0);
    checkOutput("reArmedNoSpur", {16'b0, oSpurious}, 32'd1);
    drain(2);

    // Spurious counter saturates.
    iSolved = 1'b1; iTaskid = 16'd9;
    repeat (70000) @(negedge iCLOCK);
    iSolved = 1'b0;
    checkOutput("spurSaturate", {16'b0, oSpurious}, 32'h0000FFFF);

    // Reset with five queued entries and one pending id.
    for (int i = 40; i <= 45; i++) issueId(16'(i));
    for (int i = 40; i <= 44; i++) solveId(16'(i), 8'(i - 40), 3'(i));
    checkOutput("preRstOutstanding", {25'b0, oOutstanding}, 32'd1);
    iReady = 1'b1;
    iRESET = 1'b1;
    @(negedge iCLOCK);
    iRESET = 1'b0;
    iReady = 1'b0;
    checkOutput("midRstValid", {31'b0, oValid}, 32'd0);
    checkOutput("midRstOutstanding", {25'b0, oOutstanding}, 32'd0);
    checkOutput("midRstSpurious", {16'b0, oSpurious}, 32'd0);
    checkOutput("midRstOverflow", {31'b0, oOverflow}, 32'd0);
    checkOutput("midRstDup", {31'b0, oDupIssue}, 32'd0);
    solveId(16'd45, 8'sd1, 3'd1);
    checkOutput("postRstSpur", {16'b0, oSpurious}, 32'd1);
    checkOutput("postRstValid", {31'b0, oValid}, 32'd0);

    @(negedge iCLOCK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
